// File: rtl/ysyx_24090003_exec_ctrl.sv
// Multi-cycle execution controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky HALT.
// Optional watchdog (ERR state, timeout_err) is built only with EXEC_CTRL_WATCHDOG_EN defined.
module ysyx_24090003_exec_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    output logic        ifu_req,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic [31:0] ir,
    output logic [2:0]  imm_type,
    output logic        lsu_req,
    output logic        lsu_wen,
    input  logic        lsu_done,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic        timeout_err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
`ifdef EXEC_CTRL_WATCHDOG_EN
        , ERR  = 3'd6
`endif
    } state_t;

    state_t     cur, nxt;
    logic [6:0] opcode;
    logic       legal, is_mem, is_store, writes_rd;

    assign opcode   = ir[6:0];
    assign is_mem   = (opcode == 7'b0000011) || (opcode == 7'b0100011);
    assign is_store = (opcode == 7'b0100011);

    always_comb begin
        imm_type = 3'b000;
        legal    = 1'b1;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm_type = 3'b001;
            7'b0100011:                                     imm_type = 3'b010;
            7'b1100011:                                     imm_type = 3'b011;
            7'b0110111, 7'b0010111:                         imm_type = 3'b100;
            7'b1101111:                                     imm_type = 3'b101;
            7'b0110011:                                     imm_type = 3'b000;
            default:                                        legal    = 1'b0;
        endcase
    end

    always_comb begin
        writes_rd = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: writes_rd = (ir[11:7] != 5'd0);
            default:                            writes_rd = 1'b0;
        endcase
    end

`ifdef EXEC_CTRL_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          wait_limit;

    assign wait_limit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Any state change clears the count, so entering FETCH or MEM always starts from zero.
    always_ff @(posedge clock) begin
        if (reset || nxt != cur)
            wait_cnt <= '0;
        else if (cur == FETCH || cur == MEM)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH: begin
                if (inst_valid) nxt = DECODE;
`ifdef EXEC_CTRL_WATCHDOG_EN
                else if (wait_limit) nxt = ERR;
`endif
            end
            DECODE: nxt = EXEC;
            EXEC: begin
                if (is_mem)                                nxt = MEM;
                else if (ir == 32'h0010_0073 || !legal)    nxt = HALT;
                else                                       nxt = WB;
            end
            MEM: begin
                if (lsu_done) nxt = WB;
`ifdef EXEC_CTRL_WATCHDOG_EN
                else if (wait_limit) nxt = ERR;
`endif
            end
            WB:   nxt = FETCH;
            HALT: nxt = HALT;
`ifdef EXEC_CTRL_WATCHDOG_EN
            ERR:  nxt = ERR;
`endif
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= FETCH;
            ir  <= 32'd0;
        end else begin
            cur <= nxt;
            if (cur == FETCH && inst_valid) ir <= inst;
        end
    end

    // Requests and write pulses are suppressed combinationally while reset is held.
    assign ifu_req = (cur == FETCH) && !reset;
    assign lsu_req = (cur == MEM) && !reset;
    assign lsu_wen = lsu_req && is_store;
    assign pc_wen  = (cur == WB) && !reset;
    assign rf_wen  = pc_wen && writes_rd;
    assign halt    = (cur == HALT);
    assign state   = cur;
`ifdef EXEC_CTRL_WATCHDOG_EN
    assign timeout_err = (cur == ERR);
`else
    assign timeout_err = 1'b0;
`endif

endmodule
